uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 111 +++++++++++
 tb/tb_uart_tx_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART serializer through an en/busy handshake with a busy timeout.
// Optional occupancy output `level` is built when UART_TX_FEEDER_LEVEL_EN is defined.
module uart_tx_feeder #(
  parameter int ADDR_W       = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             tmo,
  output logic             uart_en,
  output logic [7:0]       uart_din,
`ifdef UART_TX_FEEDER_LEVEL_EN
  output logic [ADDR_W:0]  level,
`endif
  input  logic             uart_tx_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [7:0]       mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             push, pop;

  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = wr_en && !full;
  // LOAD is only entered with data present, so the pop never underflows.
  assign pop   = (state == S_LOAD);

  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;

  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)        wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop)         rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      if (wr_en && full) ovf  <= 1'b1;
    end

`ifdef UART_TX_FEEDER_LEVEL_EN
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) level <= '0;
    else begin
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
`endif

  // Handshake FSM; uart_din is only ever loaded from memory, never bypassed.
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      uart_en  <= 1'b0;
      uart_din <= 8'h00;
      tmo      <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (state)
        S_IDLE:
          if (!empty && !uart_tx_busy) state <= S_LOAD;
        S_LOAD: begin
          uart_din <= mem[rd_ptr[ADDR_W-1:0]];
          uart_en  <= 1'b1;
          cnt      <= '0;
          state    <= S_REQ;
        end
        S_REQ:
          if (uart_tx_busy) begin
            uart_en <= 1'b0;
            state   <= S_WAIT;
          end else if (cnt == CNT_LAST) begin
            uart_en <= 1'b0;
            tmo     <= 1'b1;
            state   <= S_IDLE;
          end else if (cnt != CNT_TOP) begin
            cnt <= cnt + CNT_W'(1);
          end
        S_WAIT:
          if (!uart_tx_busy) state <= S_IDLE;
        default: begin
          state   <= S_IDLE;
          uart_en <= 1'b0;
        end
      endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural serializer busy model.
module tb_uart_tx_feeder;
  localparam int ADDR_W = 8;
  localparam int BT     = 15;

  logic sys_clk = 1'b0;
  logic sys_rst, wr_en, uart_tx_busy;
  logic [7:0] wr_data, uart_din;
  logic full, empty, ovf, tmo, uart_en;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [ADDR_W:0] level;
`endif
  logic model_on, hold_busy, mbusy, mdl_prev, mon_prev;
  logic [7:0] mon_held;
  logic [7:0] got [$];
  int rises = 0, busy_rise_err = 0, din_err = 0;
  int pass_cnt = 0, tot_cnt = 0;

  assign uart_tx_busy = hold_busy | mbusy;
  always #5 sys_clk = ~sys_clk;

  uart_tx_feeder #(.ADDR_W(ADDR_W), .BUSY_TIMEOUT(BT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .ovf(ovf), .tmo(tmo), .uart_en(uart_en),
    .uart_din(uart_din),
`ifdef UART_TX_FEEDER_LEVEL_EN
    .level(level),
`endif
    .uart_tx_busy(uart_tx_busy));

  // Serializer: busy rises 2 cycles after the uart_en rising edge, holds 100 cycles.
  initial begin
    mbusy = 1'b0; mdl_prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (model_on && uart_en && !mdl_prev) begin
        @(negedge sys_clk);
        mbusy = 1'b1;
        repeat (100) @(negedge sys_clk);
        mbusy = 1'b0;
        mdl_prev = 1'b0;
      end else mdl_prev = uart_en;
    end
  end

  initial begin
    mon_prev = 1'b0; mon_held = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (uart_en && !mon_prev) begin
        got.push_back(uart_din);
        rises++;
        if (uart_tx_busy) busy_rise_err++;
        mon_held = uart_din;
      end else if (uart_en && uart_din != mon_held) din_err++;
      mon_prev = uart_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_drain(input int budget, input int want, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge sys_clk);
      if (rises >= want && empty && !uart_en && !uart_tx_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #3;
    tot_cnt++; if (empty !== 1'b1)    $display("FAIL reset_empty got %b want 1", empty);    else pass_cnt++;
    tot_cnt++; if (full !== 1'b0)     $display("FAIL reset_full got %b want 0", full);      else pass_cnt++;
    tot_cnt++; if (uart_en !== 1'b0)  $display("FAIL reset_en got %b want 0", uart_en);     else pass_cnt++;
    tot_cnt++; if (uart_din !== 8'h00) $display("FAIL reset_din got %h want 00", uart_din); else pass_cnt++;
    tot_cnt++; if (ovf !== 1'b0)      $display("FAIL reset_ovf got %b want 0", ovf);        else pass_cnt++;
    tot_cnt++; if (tmo !== 1'b0)      $display("FAIL reset_tmo got %b want 0", tmo);        else pass_cnt++;
    @(negedge sys_clk); sys_rst = 1'b0;
    tick(3);
    tot_cnt++; if (uart_en !== 1'b0 || rises != 0)
      $display("FAIL release_spurious_en en=%b rises=%0d want 0/0", uart_en, rises); else pass_cnt++;
  endtask

  task automatic test_single();
    int start; bit ok;
    model_on = 1'b1; start = rises;
    @(negedge sys_clk); wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge sys_clk); wr_en = 1'b0;
    tot_cnt++; if (empty !== 1'b0 || uart_en !== 1'b0)
      $display("FAIL single_n1 empty=%b en=%b want 0/0", empty, uart_en); else pass_cnt++;
    @(negedge sys_clk);
    tot_cnt++; if (uart_en !== 1'b0) $display("FAIL single_load_en got %b want 0", uart_en); else pass_cnt++;
    @(negedge sys_clk);
    tot_cnt++; if (uart_en !== 1'b1 || uart_din !== 8'hA5 || empty !== 1'b1)
      $display("FAIL single_req en=%b din=%h empty=%b want 1/a5/1", uart_en, uart_din, empty); else pass_cnt++;
    @(negedge sys_clk);
    tot_cnt++; if (uart_en !== 1'b1) $display("FAIL single_hold_en got %b want 1", uart_en); else pass_cnt++;
    @(negedge sys_clk);
    tot_cnt++; if (uart_en !== 1'b0) $display("FAIL single_drop_en got %b want 0", uart_en); else pass_cnt++;
    wait_drain(300, start + 1, ok);
    tot_cnt++; if (!ok || rises - start != 1)
      $display("FAIL single_drain ok=%b rises=%0d want 1/1", ok, rises - start); else pass_cnt++;
  endtask

  task automatic test_burst();
    int start, q0, bad; bit ok;
    model_on = 1'b1; start = rises; q0 = got.size(); busy_rise_err = 0; din_err = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clk); wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge sys_clk); wr_en = 1'b0;
    wait_drain(3000, start + 16, ok);
    tot_cnt++; if (!ok || rises - start != 16)
      $display("FAIL burst_count ok=%b rises=%0d want 1/16", ok, rises - start); else pass_cnt++;
    for (int i = 0; i < 16 && q0 + i < got.size(); i++) if (got[q0+i] != 8'(i)) bad++;
    tot_cnt++; if (bad != 0) $display("FAIL burst_order bad=%0d want 0", bad); else pass_cnt++;
    tot_cnt++; if (busy_rise_err != 0 || din_err != 0)
      $display("FAIL burst_handshake busy_err=%0d din_err=%0d want 0/0", busy_rise_err, din_err); else pass_cnt++;
  endtask

  task automatic test_full();
    int start, q0, bad; bit ok;
    model_on = 1'b1; hold_busy = 1'b1; start = rises; q0 = got.size(); bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge sys_clk);
      if (i == 255) begin
        tot_cnt++; if (full !== 1'b0) $display("FAIL full_at255 got %b want 0", full); else pass_cnt++;
      end
      wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge sys_clk); wr_data = 8'hEE;
    tot_cnt++; if (full !== 1'b1 || ovf !== 1'b0)
      $display("FAIL full_at256 full=%b ovf=%b want 1/0", full, ovf); else pass_cnt++;
    @(negedge sys_clk); wr_en = 1'b0;
    tot_cnt++; if (full !== 1'b1 || ovf !== 1'b1)
      $display("FAIL full_drop full=%b ovf=%b want 1/1", full, ovf); else pass_cnt++;
    hold_busy = 1'b0;
    wait_drain(30000, start + 256, ok);
    tick(5);
    tot_cnt++; if (!ok || rises - start != 256)
      $display("FAIL full_drain ok=%b rises=%0d want 1/256", ok, rises - start); else pass_cnt++;
    for (int i = 0; i < 256 && q0 + i < got.size(); i++) if (got[q0+i] != 8'(i)) bad++;
    tot_cnt++; if (bad != 0) $display("FAIL full_order bad=%0d want 0", bad); else pass_cnt++;
    tot_cnt++; if (ovf !== 1'b1 || empty !== 1'b1)
      $display("FAIL full_sticky ovf=%b empty=%b want 1/1", ovf, empty); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int start, n, dbad;
    model_on = 1'b0; start = rises; n = 0; dbad = 0;
    @(negedge sys_clk); wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge sys_clk); wr_en = 1'b0;
    for (int c = 0; c < 10 && !uart_en; c++) @(negedge sys_clk);
    while (uart_en && n < 100) begin
      if (uart_din !== 8'h3C) dbad++;
      n++;
      @(negedge sys_clk);
    end
    tot_cnt++; if (n != BT || dbad != 0)
      $display("FAIL tmo_en_width got %0d cycles (din_bad=%0d) want %0d", n, dbad, BT); else pass_cnt++;
    tot_cnt++; if (tmo !== 1'b1 || uart_en !== 1'b0 || empty !== 1'b1)
      $display("FAIL tmo_pulse tmo=%b en=%b empty=%b want 1/0/1", tmo, uart_en, empty); else pass_cnt++;
    @(negedge sys_clk);
    tot_cnt++; if (tmo !== 1'b0) $display("FAIL tmo_one_cycle got %b want 0", tmo); else pass_cnt++;
    tick(3);
    tot_cnt++; if (uart_en !== 1'b0 || rises - start != 1)
      $display("FAIL tmo_idle en=%b rises=%0d want 0/1", uart_en, rises - start); else pass_cnt++;
  endtask

  task automatic test_reset_req();
    int start;
    model_on = 1'b0; start = rises;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk); wr_en = 1'b1; wr_data = 8'h11 + 8'(i);
    end
    @(negedge sys_clk); wr_en = 1'b0;
    for (int c = 0; c < 10 && !uart_en; c++) @(negedge sys_clk);
    tot_cnt++; if (uart_en !== 1'b1) $display("FAIL rreq_en_before got %b want 1", uart_en); else pass_cnt++;
    #2 sys_rst = 1'b1;
    #1;
    tot_cnt++; if (uart_en !== 1'b0 || empty !== 1'b1 || ovf !== 1'b0)
      $display("FAIL rreq_async en=%b empty=%b ovf=%b want 0/1/0", uart_en, empty, ovf); else pass_cnt++;
    @(negedge sys_clk); sys_rst = 1'b0;
    tick(20);
    tot_cnt++; if (empty !== 1'b1 || ovf !== 1'b0 || uart_en !== 1'b0 || rises - start != 1)
      $display("FAIL rreq_after empty=%b ovf=%b en=%b rises=%0d want 1/0/0/1",
               empty, ovf, uart_en, rises - start); else pass_cnt++;
  endtask

`ifdef UART_TX_FEEDER_LEVEL_EN
  task automatic test_level();
    model_on = 1'b0; hold_busy = 1'b1;
    @(negedge sys_clk); wr_en = 1'b1; wr_data = 8'h40;
    for (int i = 1; i <= 3; i++) begin
      @(negedge sys_clk);
      if (i < 3) wr_data = 8'h40 + 8'(i); else wr_en = 1'b0;
      tot_cnt++; if (level !== (ADDR_W+1)'(i)) $display("FAIL level_step got %0d want %0d", level, i); else pass_cnt++;
    end
    hold_busy = 1'b0;
    @(negedge sys_clk); hold_busy = 1'b1;
    tot_cnt++; if (level !== 9'd3) $display("FAIL level_in_load got %0d want 3", level); else pass_cnt++;
    @(negedge sys_clk);
    tot_cnt++; if (level !== 9'd2 || uart_en !== 1'b1)
      $display("FAIL level_after_load level=%0d en=%b want 2/1", level, uart_en); else pass_cnt++;
    @(negedge sys_clk); hold_busy = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk); wr_en = 1'b1; wr_data = 8'h50;
    tot_cnt++; if (level !== 9'd2) $display("FAIL level_pre_pushpop got %0d want 2", level); else pass_cnt++;
    @(negedge sys_clk); wr_en = 1'b0;
    tot_cnt++; if (level !== 9'd2 || uart_en !== 1'b1)
      $display("FAIL level_pushpop level=%0d en=%b want 2/1", level, uart_en); else pass_cnt++;
  endtask
`endif

  initial begin
    sys_rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; model_on = 1'b0; hold_busy = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_timeout();
    test_reset_req();
`ifdef UART_TX_FEEDER_LEVEL_EN
    test_level();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
